// File: rtl/control_word_gen_pkg.sv
// Shared definitions for the control word: field positions, debounce default
// and the pulse generator state type. Consumers of the control word import this too.
package control_word_gen_pkg;

    localparam int DEBOUNCE_DEFAULT = 650000;

    localparam int CW_WIDTH   = 15;
    localparam int VALUE_LSB  = 0;
    localparam int VALUE_MSB  = 7;
    localparam int SEL_T      = 10;
    localparam int SEL_F      = 11;
    localparam int ENTER      = 12;
    localparam int MODE_LSB   = 13;
    localparam int MODE_MSB   = 14;

    // Layout of the raw input bus feeding the debouncers
    localparam int NUM_INPUTS = 13;
    localparam int IN_MODE_LSB = 8;
    localparam int IN_MODE_MSB = 9;
    localparam int IN_BTN_LSB  = 10;
    localparam int IN_BTN_MSB  = 12;

    // Bit order of the three-button group {sel_t, sel_f, enter}
    localparam int BTN_ENTER = 0;
    localparam int BTN_SEL_F = 1;
    localparam int BTN_SEL_T = 2;

    typedef enum logic {
        IDLE,
        ENTER_PENDING
    } pulse_state_t;

endpackage

// File: rtl/control_word_gen_debounce_sync.sv
// One input bit: two-flop synchronizer followed by a saturating stability counter.
// The debounced output flips only after the synchronized bit disagrees for DEBOUNCE_CYCLES cycles.
module debounce_sync
    import control_word_gen_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
    input  logic clock,
    input  logic reset,
    input  logic raw,
    output logic debounced
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             meta;
    logic             sync;
    logic [CNT_W-1:0] count;

    // Count never passes LAST: reaching it flips the output and clears the count.
    always_ff @(posedge clock) begin
        if (reset) begin
            meta      <= 1'b0;
            sync      <= 1'b0;
            count     <= '0;
            debounced <= 1'b0;
        end else begin
            meta <= raw;
            sync <= meta;
            if (sync != debounced) begin
                if (count >= LAST) begin
                    debounced <= sync;
                    count     <= '0;
                end else begin
                    count <= count + CNT_W'(1);
                end
            end else begin
                count <= '0;
            end
        end
    end

endmodule

// File: rtl/control_word_gen.sv
// Turns raw switches and buttons into a registered control word: debounced value
// and mode fields plus arbitrated single-cycle select/enter pulses.
module control_word_gen
    import control_word_gen_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [7:0]          switches,
    input  logic [1:0]          mode_sw,
    input  logic                btn_enter,
    input  logic                btn_sel_f,
    input  logic                btn_sel_t,
    output logic [CW_WIDTH-1:0] controls
);

    // Buttons may only arm once the whole input path has had time to reflect the real level
    localparam int WARM_W = $clog2(DEBOUNCE_CYCLES + 3);
    localparam logic [WARM_W-1:0] WARM_DONE = WARM_W'(DEBOUNCE_CYCLES + 2);

    logic [NUM_INPUTS-1:0] raw_bus;
    logic [NUM_INPUTS-1:0] deb_bus;

    assign raw_bus = {btn_sel_t, btn_sel_f, btn_enter, mode_sw, switches};

    for (genvar i = 0; i < NUM_INPUTS; i++) begin : g_deb
        debounce_sync #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_deb (
            .clock    (clock),
            .reset    (reset),
            .raw      (raw_bus[i]),
            .debounced(deb_bus[i])
        );
    end

    logic [2:0]        btn_deb;
    logic [2:0]        btn_prev;
    logic [2:0]        btn_armed;
    logic [2:0]        btn_rise;
    logic [WARM_W-1:0] warm;
    logic              value_changed;
    logic              value_moving;
    logic [7:0]        value_next;
    logic              sel_f_pulse;
    logic              sel_t_pulse;
    logic              enter_req;
    logic              enter_issue;
    pulse_state_t      state;
    pulse_state_t      state_next;
    logic [CW_WIDTH-1:0] controls_next;

    assign btn_deb    = deb_bus[IN_BTN_MSB:IN_BTN_LSB];
    assign btn_rise   = btn_deb & ~btn_prev & btn_armed;
    assign value_next = deb_bus[7:0];

    // Enter waits out any select pulse and any value change in this or the previous cycle.
    always_comb begin
        state_next    = state;
        controls_next = '0;

        sel_f_pulse  = btn_rise[BTN_SEL_F];
        sel_t_pulse  = btn_rise[BTN_SEL_T] & ~btn_rise[BTN_SEL_F];
        value_moving = (value_next != controls[VALUE_MSB:VALUE_LSB]);
        enter_req    = btn_rise[BTN_ENTER] | (state == ENTER_PENDING);
        enter_issue  = enter_req & ~(sel_f_pulse | sel_t_pulse | value_moving | value_changed);

        if (enter_issue) begin
            state_next = IDLE;
        end else if (enter_req) begin
            state_next = ENTER_PENDING;
        end

        controls_next[VALUE_MSB:VALUE_LSB] = value_next;
        controls_next[MODE_MSB:MODE_LSB]   = deb_bus[IN_MODE_MSB:IN_MODE_LSB];
        controls_next[SEL_T]               = sel_t_pulse;
        controls_next[SEL_F]               = sel_f_pulse;
        controls_next[ENTER]               = enter_issue;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            btn_prev      <= '0;
            btn_armed     <= '0;
            warm          <= '0;
            value_changed <= 1'b0;
            state         <= IDLE;
            controls      <= '0;
        end else begin
            btn_prev      <= btn_deb;
            value_changed <= value_moving;
            state         <= state_next;
            controls      <= controls_next;
            if (warm == WARM_DONE) begin
                btn_armed <= btn_armed | ~btn_deb;
            end else begin
                warm <= warm + WARM_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_control_word_gen.sv
// Directed bench for control_word_gen with a short debounce window of 4 cycles,
// so raw-to-output latency is 7 cycles.
module tb_control_word_gen;
    import control_word_gen_pkg::*;

    logic                clock = 1'b0;
    logic                reset;
    logic [7:0]          switches;
    logic [1:0]          mode_sw;
    logic                btn_enter;
    logic                btn_sel_f;
    logic                btn_sel_t;
    logic [CW_WIDTH-1:0] controls;

    int errors = 0;
    int checks = 0;
    int cyc, cnt_e, cnt_f, cnt_t, first_e, first_f, first_t;
    int multi_hot = 0;
    int zero_bad  = 0;
    int stab_bad  = 0;
    logic [7:0] prev_val;

    control_word_gen #(
        .DEBOUNCE_CYCLES(4)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .switches (switches),
        .mode_sw  (mode_sw),
        .btn_enter(btn_enter),
        .btn_sel_f(btn_sel_f),
        .btn_sel_t(btn_sel_t),
        .controls (controls)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic clear_counts();
        cyc = 0; cnt_e = 0; cnt_f = 0; cnt_t = 0;
        first_e = 0; first_f = 0; first_t = 0;
        prev_val = controls[VALUE_MSB:VALUE_LSB];
    endtask

    // Advance n cycles, tallying pulses and watching the invariants of the word
    task automatic window(input int n);
        logic [2:0] p;
        for (int i = 0; i < n; i++) begin
            tick();
            cyc++;
            p = controls[ENTER:SEL_T];
            if ($countones(p) > 1) multi_hot++;
            if (controls[9:8] !== 2'b00) zero_bad++;
            if (controls[ENTER]) begin
                cnt_e++;
                if (first_e == 0) first_e = cyc;
                if (controls[VALUE_MSB:VALUE_LSB] !== prev_val) stab_bad++;
            end
            if (controls[SEL_F]) begin
                cnt_f++;
                if (first_f == 0) first_f = cyc;
            end
            if (controls[SEL_T]) begin
                cnt_t++;
                if (first_t == 0) first_t = cyc;
            end
            prev_val = controls[VALUE_MSB:VALUE_LSB];
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset = 1'b1; switches = 8'h00; mode_sw = 2'b00;
        btn_enter = 1'b0; btn_sel_f = 1'b0; btn_sel_t = 1'b0;
        ticks(3);
        check("reset_controls", 32'(controls), 32'h0);
        reset = 1'b0;
        ticks(10);
        check("idle_controls", 32'(controls), 32'h0);

        // Value field latency
        switches = 8'hA5;
        ticks(6);
        check("value_before_latency", 32'(controls[VALUE_MSB:VALUE_LSB]), 32'h00);
        tick();
        check("value_at_latency", 32'(controls[VALUE_MSB:VALUE_LSB]), 32'hA5);
        check("value_no_pulses", 32'(controls[ENTER:SEL_T]), 32'h0);
        check("zero_bits", 32'(controls[9:8]), 32'h0);

        // Mode field latency
        mode_sw = 2'b10;
        ticks(6);
        check("mode_before_latency", 32'(controls[MODE_MSB:MODE_LSB]), 32'h0);
        tick();
        check("mode_at_latency", 32'(controls[MODE_MSB:MODE_LSB]), 32'h2);

        // Short glitch on enter is rejected
        clear_counts();
        btn_enter = 1'b1;
        window(3);
        btn_enter = 1'b0;
        window(20);
        check("enter_glitch_pulses", 32'(cnt_e), 32'd0);

        // Held enter gives exactly one pulse
        clear_counts();
        btn_enter = 1'b1;
        window(20);
        btn_enter = 1'b0;
        window(12);
        check("enter_hold_pulses", 32'(cnt_e), 32'd1);
        check("enter_latency", 32'(first_e), 32'd7);

        // Simultaneous selects: F wins, T dropped
        clear_counts();
        btn_sel_f = 1'b1; btn_sel_t = 1'b1;
        window(20);
        btn_sel_f = 1'b0; btn_sel_t = 1'b0;
        window(12);
        check("self_pulses", 32'(cnt_f), 32'd1);
        check("selt_dropped", 32'(cnt_t), 32'd0);
        check("self_latency", 32'(first_f), 32'd7);

        // Select-T with enter: T first, enter one cycle later
        clear_counts();
        btn_sel_t = 1'b1; btn_enter = 1'b1;
        window(20);
        btn_sel_t = 1'b0; btn_enter = 1'b0;
        window(12);
        check("selt_enter_t_pulses", 32'(cnt_t), 32'd1);
        check("selt_enter_e_pulses", 32'(cnt_e), 32'd1);
        check("selt_enter_t_at", 32'(first_t), 32'd7);
        check("selt_enter_e_at", 32'(first_e), 32'd8);

        // Value update in the cycle before a due enter defers it by one cycle
        switches = 8'h3C;
        tick();
        btn_enter = 1'b1;
        ticks(6);
        check("defer_value_updated", 32'(controls[VALUE_MSB:VALUE_LSB]), 32'h3C);
        check("defer_no_enter_yet", 32'(controls[ENTER]), 32'h0);
        tick();
        check("defer_enter_held_back", 32'(controls[ENTER]), 32'h0);
        tick();
        check("defer_enter_issued", 32'(controls[ENTER]), 32'h1);
        check("defer_value_stable", 32'(controls[VALUE_MSB:VALUE_LSB]), 32'h3C);
        tick();
        check("defer_enter_single", 32'(controls[ENTER]), 32'h0);
        btn_enter = 1'b0;
        ticks(12);

        // Reset in the middle of a debounce discards it
        btn_enter = 1'b1;
        ticks(5);
        reset = 1'b1;
        btn_enter = 1'b0;
        ticks(2);
        check("midreset_controls", 32'(controls), 32'h0);
        reset = 1'b0;
        clear_counts();
        window(20);
        check("midreset_no_pulse", 32'(cnt_e + cnt_f + cnt_t), 32'd0);
        check("midreset_value_back", 32'(controls[VALUE_MSB:VALUE_LSB]), 32'h3C);

        // Button held through reset stays silent until released and pressed again
        btn_enter = 1'b1;
        reset = 1'b1;
        ticks(3);
        reset = 1'b0;
        clear_counts();
        window(50);
        check("held_reset_no_pulse", 32'(cnt_e), 32'd0);
        btn_enter = 1'b0;
        window(12);
        check("held_release_no_pulse", 32'(cnt_e), 32'd0);
        clear_counts();
        btn_enter = 1'b1;
        window(20);
        check("repress_one_pulse", 32'(cnt_e), 32'd1);
        check("repress_latency", 32'(first_e), 32'd7);
        btn_enter = 1'b0;
        ticks(10);

        check("never_multi_hot", 32'(multi_hot), 32'd0);
        check("zero_bits_always", 32'(zero_bad), 32'd0);
        check("enter_value_stable", 32'(stab_bad), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
